// File: rtl/ro_puf_pkg.sv
// Shared constants and FSM state type for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

    localparam int unsigned NUM_RO    = 128;
    localparam int unsigned RO_IDX_W  = 7;
    localparam int unsigned MUX_SEL_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        COUNT,
        HOLD,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter timing both the settle and the count window phases.
module ro_puf_window_timer
    import ro_puf_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] remain;

    // Loading N gives N+1 cycles until the phase ends on the expire cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (remain != '0) begin
            remain <= remain - W'(1);
        end
    end

    assign expire_c = (remain == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Steps RO pairs from a challenge seed, gates the edge counters and builds the response.
// Optional build macro RO_PUF_TIE_FLAG_EN adds the tie_mask output flagging equal counts.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int unsigned RESP_BITS  = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RO_IDX_W-1:0]  seed,
    output logic [MUX_SEL_W-1:0] sel_a,
    output logic [MUX_SEL_W-1:0] sel_b,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid
`ifdef RO_PUF_TIE_FLAG_EN
    ,
    output logic [RESP_BITS-1:0] tie_mask
`endif
);

    localparam int unsigned TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_t              state;
    logic [RO_IDX_W-1:0] base;
    logic [K_W-1:0]      k;

    logic                tmr_load_c;
    logic                tmr_expire_c;
    logic [TMR_W-1:0]    tmr_val_c;
    logic [RO_IDX_W-1:0] base_next_c;
    logic                last_c;

    // Timer is armed on the way out of CLEAR (settle) and out of SETTLE (window).
    assign tmr_load_c  = (state == CLEAR) || ((state == SETTLE) && tmr_expire_c);
    assign tmr_val_c   = (state == CLEAR) ? TMR_W'(SETTLE_CYC - 1) : TMR_W'(WINDOW - 1);
    assign base_next_c = base + RO_IDX_W'(2);
    assign last_c      = (k == K_W'(RESP_BITS - 1));

    ro_puf_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire_c (tmr_expire_c)
    );

    // Outputs are registered on the edge entering each phase, so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            k          <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
`ifdef RO_PUF_TIE_FLAG_EN
            tie_mask   <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cnt_clr <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the first IDLE cycle; a start there is dropped.
                    if (start && !done) begin
                        base       <= seed;
                        k          <= '0;
                        busy       <= 1'b1;
                        resp_valid <= 1'b0;
                        resp       <= '0;
`ifdef RO_PUF_TIE_FLAG_EN
                        tie_mask   <= '0;
`endif
                        sel_a      <= {1'b0, seed};
                        sel_b      <= {1'b0, seed + RO_IDX_W'(1)};
                        cnt_clr    <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (tmr_expire_c) begin
                        cnt_en <= 1'b1;
                        state  <= COUNT;
                    end
                end
                COUNT: begin
                    if (tmr_expire_c) begin
                        cnt_en <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    resp[k] <= (cnt_a > cnt_b);
`ifdef RO_PUF_TIE_FLAG_EN
                    tie_mask[k] <= (cnt_a == cnt_b);
`endif
                    if (last_c) begin
                        state <= DONE;
                    end else begin
                        k       <= k + K_W'(1);
                        base    <= base_next_c;
                        sel_a   <= {1'b0, base_next_c};
                        sel_b   <= {1'b0, base_next_c + RO_IDX_W'(1)};
                        cnt_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Scoreboard bench for ro_puf_sequencer with a per-oscillator frequency model.
module tb_ro_puf_sequencer;

    localparam int unsigned RESP_BITS  = 8;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned WINDOW     = 256;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned BIT_CYC    = SETTLE_CYC + WINDOW + 3;
    localparam int unsigned LAT        = RESP_BITS * BIT_CYC + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [6:0]           seed = '0;
    logic [7:0]           sel_a;
    logic [7:0]           sel_b;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_W-1:0]     cnt_a = '0;
    logic [CNT_W-1:0]     cnt_b = '0;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] resp;
    logic                 resp_valid;
`ifdef RO_PUF_TIE_FLAG_EN
    logic [RESP_BITS-1:0] tie_mask;
`endif

    ro_puf_sequencer #(
        .RESP_BITS  (RESP_BITS),
        .SETTLE_CYC (SETTLE_CYC),
        .WINDOW     (WINDOW),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .busy       (busy),
        .done       (done),
        .resp       (resp),
        .resp_valid (resp_valid)
`ifdef RO_PUF_TIE_FLAG_EN
        ,
        .tie_mask   (tie_mask)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [RESP_BITS-1:0] resp;
        logic [RESP_BITS-1:0] tie;
        int unsigned          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sel_q[$];

    logic [CNT_W-1:0] ro_freq [128];

    int unsigned en_run = 0;
    int unsigned clr_gap = 0;
    bit          gap_armed = 0;
    bit          prev_done = 0;
    int          pair_in_seq = 0;
    int          done_seen = 0;
    bit          cnt_seen_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Edge counters: cleared by cnt_clr, noisy while counting, the oscillator frequencies once gated off.
    always @(negedge clk) begin
        if (rst || cnt_clr) begin
            cnt_seen_en = 1'b0;
            cnt_a = '0;
            cnt_b = '0;
        end else if (cnt_en) begin
            cnt_seen_en = 1'b1;
            cnt_a = CNT_W'($urandom);
            cnt_b = CNT_W'($urandom);
        end else if (cnt_seen_en) begin
            cnt_a = ro_freq[sel_a[6:0]];
            cnt_b = ro_freq[sel_b[6:0]];
        end
    end

    // Monitor: pops expectations whenever the DUT clears counters or signals completion.
    always @(negedge clk) begin
        if (rst) begin
            en_run    = 0;
            gap_armed = 0;
            prev_done = 0;
        end else begin
            if (cnt_en) begin
                en_run++;
            end else if (en_run != 0) begin
                check("cnt_en_window", 64'(en_run), 64'(WINDOW));
                en_run = 0;
            end
            if (gap_armed) begin
                clr_gap++;
                if (cnt_en) begin
                    check("clr_to_count", 64'(clr_gap), 64'(SETTLE_CYC + 1));
                    gap_armed = 0;
                end
            end
            if (cnt_clr) begin
                if (sel_q.size() == 0) begin
                    check("unexpected_clr", 64'(1), 64'(0));
                end else begin
                    logic [15:0] p;
                    p = sel_q.pop_front();
                    check("sel_a", 64'(sel_a), 64'(p[15:8]));
                    check("sel_b", 64'(sel_b), 64'(p[7:0]));
                end
                check("busy_in_seq", 64'(busy), 64'(1));
                check("resp_valid_low", 64'(resp_valid), 64'(0));
                gap_armed = 1;
                clr_gap = 0;
                pair_in_seq++;
            end
            if (done) begin
                done_seen++;
                check("done_pulse", 64'(prev_done), 64'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp", 64'(resp), 64'(e.resp));
                    check("latency", 64'(cyc - e.start_cyc), 64'(LAT));
                    check("resp_valid", 64'(resp_valid), 64'(1));
                    check("busy_at_done", 64'(busy), 64'(0));
`ifdef RO_PUF_TIE_FLAG_EN
                    check("tie_mask", 64'(tie_mask), 64'(e.tie));
`endif
                end
            end
            prev_done = done;
        end
    end

    // Reference: pair k compares oscillators (s+2k) mod 128 and (s+2k+1) mod 128.
    task automatic issue(input int s);
        exp_t e;
        e.resp = '0;
        e.tie  = '0;
        for (int k = 0; k < RESP_BITS; k++) begin
            int ia;
            int ib;
            ia = (s + 2 * k) % 128;
            ib = (s + 2 * k + 1) % 128;
            e.resp[k] = (ro_freq[ia] > ro_freq[ib]);
            e.tie[k]  = (ro_freq[ia] == ro_freq[ib]);
            sel_q.push_back({8'(ia), 8'(ib)});
        end
        @(negedge clk);
        #1;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        pair_in_seq = 0;
        seed  = 7'(s);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        seed  = 7'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int target;
        bit got;
        target = done_seen + 1;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_seen >= target) begin
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel_a"}, 64'(sel_a), 64'(0));
        check({tag, "_sel_b"}, 64'(sel_b), 64'(0));
        check({tag, "_cnt_clr"}, 64'(cnt_clr), 64'(0));
        check({tag, "_cnt_en"}, 64'(cnt_en), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_resp"}, 64'(resp), 64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
`ifdef RO_PUF_TIE_FLAG_EN
        check({tag, "_tie_mask"}, 64'(tie_mask), 64'(0));
`endif
    endtask

    task automatic rand_freq(input int unsigned maxv);
        for (int i = 0; i < 128; i++) ro_freq[i] = CNT_W'($urandom_range(0, maxv));
    endtask

    task automatic alt_freq(input int s);
        rand_freq(65535);
        for (int k = 0; k < RESP_BITS; k++) begin
            ro_freq[(s + 2 * k) % 128]     = (k % 2 == 0) ? CNT_W'(100) : CNT_W'(90);
            ro_freq[(s + 2 * k + 1) % 128] = (k % 2 == 0) ? CNT_W'(90) : CNT_W'(100);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rand_freq(65535);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Alternating frequencies from seed 0.
        alt_freq(0);
        issue(0);
        wait_done(LAT + 50);

        // Wrap of the oscillator index past 127.
        rand_freq(65535);
        issue(125);
        wait_done(LAT + 50);

        // Stray start mid-sequence, then a start coinciding with done.
        alt_freq(0);
        issue(0);
        repeat (497) @(negedge clk);
        #1;
        start = 1'b1;
        seed  = 7'd33;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(LAT + 50);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("start_on_done_ignored", 64'(busy), 64'(0));

        // Reset while counting pair 3, then a clean full run.
        rand_freq(65535);
        issue(int'($urandom_range(0, 127)));
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (pair_in_seq == 4 && cnt_en) break;
        end
        check("reached_pair3_count", 64'(cnt_en), 64'(1));
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        sel_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(int'($urandom_range(0, 127)));
        wait_done(LAT + 50);

        // Equal counts on pair 5.
        rand_freq(65535);
        ro_freq[(10 + 10) % 128] = CNT_W'(200);
        ro_freq[(10 + 11) % 128] = CNT_W'(200);
        issue(10);
        wait_done(LAT + 50);

        // Random seeds with a narrow frequency spread so ties are common.
        for (int t = 0; t < 5; t++) begin
            rand_freq(3);
            issue(int'($urandom_range(0, 127)));
            wait_done(LAT + 50);
        end

        repeat (5) @(negedge clk);
        check("queues_drained", 64'(exp_q.size() + sel_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
